// File: rtl/mem_store_packer.sv
// Store-side memory interface: narrows a register value onto the word bus with byte enables,
// rejects misaligned or bad-size stores, and runs a req/ack handshake that aborts after TIMEOUT cycles.
module mem_store_packer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic        busy,
    output logic        dbg_state_o
);

    // Handshake: a store is taken when in_valid && in_ready at a rising edge; in_ready is
    // high only in IDLE. A memory write is held (mem_req with stable addr/wdata/be) until
    // mem_ack is sampled high at a rising edge, or until the timeout fires.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0] pack_wdata;
    logic [3:0]  pack_be;
    logic        bad_size;
    logic        misaligned;

    always_comb begin
        pack_wdata = in_data;
        pack_be    = 4'b1111;
        case (in_size)
            SZ_BYTE: begin
                pack_wdata = {4{in_data[7:0]}};
                pack_be    = 4'b0001 << in_addr[1:0];
            end
            SZ_HALF: begin
                pack_wdata = {2{in_data[15:0]}};
                pack_be    = in_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                pack_wdata = in_data;
                pack_be    = 4'b1111;
            end
        endcase
    end

    assign bad_size   = (in_size == 2'b11);
    assign misaligned = ((in_size == SZ_HALF) && in_addr[0]) ||
                        ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        baddr_d     = baddr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (bad_size) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_SIZE;
                        err_addr_d  = in_addr;
                    end else if (misaligned) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_MISALIGN;
                        err_addr_d  = in_addr;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                        addr_d  = {in_addr[31:2], 2'b00};
                        baddr_d = in_addr;
                        wdata_d = pack_wdata;
                        be_d    = pack_be;
                    end
                end
            end
            REQ: begin
                // An ack arriving on the last allowed cycle still counts as completion.
                if (mem_ack) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    err_addr_d  = baddr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            baddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            baddr_q     <= baddr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == REQ);
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    // Byte enables are gated so an idle bus never advertises a write lane.
    assign mem_be      = (state_q == REQ) ? be_q : 4'b0000;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign err_addr    = err_addr_q;
    assign dbg_state_o = state_q;

endmodule
